// File: rtl/axil_reg_bank_if.sv
// rtl/axil_reg_bank_if.sv - AXI4-Lite bus bundle for the control-plane register bank
interface axil_reg_bank_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - AXI4-Lite slave register bank with control, status and sticky IRQ registers
module axil_reg_bank #(
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic                 axilite_clk,
  input  logic                 axilite_rst,
  axil_reg_bank_if.slave       s_axil,
  input  logic [31:0]          status_i,
  input  logic [7:0]           irq_src_i,
  output logic [31:0]          ctrl_o,
  output logic [31:0]          cmd_pulse_o,
  output logic                 irq_o
);

  localparam logic [1:0] WR_IDLE  = 2'd0;
  localparam logic [1:0] WR_WRITE = 2'd1;
  localparam logic [1:0] WR_RESP  = 2'd2;

  localparam logic RD_IDLE = 1'b0;
  localparam logic RD_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word indices within the 32-byte window.
  localparam logic [2:0] IDX_VERSION = 3'd0;
  localparam logic [2:0] IDX_SCRATCH = 3'd1;
  localparam logic [2:0] IDX_CTRL    = 3'd2;
  localparam logic [2:0] IDX_STATUS  = 3'd3;
  localparam logic [2:0] IDX_IRQSTAT = 3'd4;
  localparam logic [2:0] IDX_IRQEN   = 3'd5;
  localparam logic [2:0] IDX_PULSE   = 3'd6;
  localparam logic [2:0] IDX_RSVD    = 3'd7;

  // Readies stay low for one cycle after reset release.
  logic              r_rdy_en;

  logic [1:0]        r_wr_state;
  logic              r_aw_got;
  logic              r_w_got;
  logic [ADDR_W-1:0] r_awaddr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;

  logic              r_rd_state;
  logic              r_rvalid;
  logic [1:0]        r_rresp;
  logic [31:0]       r_rdata;

  logic [31:0]       r_scratch;
  logic [31:0]       r_ctrl;
  logic [7:0]        r_irq_stat;
  logic [7:0]        r_irq_en;
  logic [31:0]       r_cmd_pulse;
  logic              r_irq;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_wr_en;
  logic [2:0]        w_wr_idx;
  logic              w_wr_err;
  logic [31:0]       w_wmask;
  logic [7:0]        w_irq_clr;
  logic [2:0]        w_rd_idx;
  logic              w_rd_err;
  logic [31:0]       w_rd_val;
  logic              w_unused;

  assign s_axil.awready = r_rdy_en && (r_wr_state == WR_IDLE) && !r_aw_got;
  assign s_axil.wready  = r_rdy_en && (r_wr_state == WR_IDLE) && !r_w_got;
  assign s_axil.bvalid  = r_bvalid;
  assign s_axil.bresp   = r_bresp;
  assign s_axil.arready = r_rdy_en && (r_rd_state == RD_IDLE);
  assign s_axil.rvalid  = r_rvalid;
  assign s_axil.rresp   = r_rresp;
  assign s_axil.rdata   = r_rdata;

  assign ctrl_o      = r_ctrl;
  assign cmd_pulse_o = r_cmd_pulse;
  assign irq_o       = r_irq;

  assign w_aw_hs = s_axil.awvalid && s_axil.awready;
  assign w_w_hs  = s_axil.wvalid  && s_axil.wready;
  assign w_ar_hs = s_axil.arvalid && s_axil.arready;

  // Protection bits and byte-lane address bits carry no meaning here.
  assign w_unused = ^{s_axil.awprot, s_axil.arprot, r_awaddr[1:0], s_axil.araddr[1:0]};

  // Write-side decode of the captured address; anything above 0x1F or the reserved word errors.
  assign w_wr_en   = (r_wr_state == WR_WRITE);
  assign w_wr_idx  = r_awaddr[4:2];
  assign w_wr_err  = (r_awaddr[ADDR_W-1:5] != '0) || (w_wr_idx == IDX_RSVD);
  assign w_wmask   = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  assign w_irq_clr = (w_wr_en && !w_wr_err && (w_wr_idx == IDX_IRQSTAT)) ?
                     (r_wdata[7:0] & w_wmask[7:0]) : 8'h00;

  // Read-side decode of the live AR address into the value to be registered.
  assign w_rd_idx = s_axil.araddr[4:2];
  assign w_rd_err = (s_axil.araddr[ADDR_W-1:5] != '0) || (w_rd_idx == IDX_RSVD);

  // Read mux; PULSE and error offsets read as zero.
  always_comb begin
    w_rd_val = 32'h0;
    case (w_rd_idx)
      IDX_VERSION: w_rd_val = VERSION;
      IDX_SCRATCH: w_rd_val = r_scratch;
      IDX_CTRL:    w_rd_val = r_ctrl;
      IDX_STATUS:  w_rd_val = status_i;
      IDX_IRQSTAT: w_rd_val = {24'h0, r_irq_stat};
      IDX_IRQEN:   w_rd_val = {24'h0, r_irq_en};
      default:     w_rd_val = 32'h0;
    endcase
    if (w_rd_err) begin
      w_rd_val = 32'h0;
    end
  end

  // Write channel FSM: capture AW and W independently, one update cycle, then hold the response.
  always_ff @(posedge axilite_clk or posedge axilite_rst) begin
    if (axilite_rst) begin
      r_rdy_en   <= 1'b0;
      r_wr_state <= WR_IDLE;
      r_aw_got   <= 1'b0;
      r_w_got    <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= 32'h0;
      r_wstrb    <= 4'h0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_rdy_en <= 1'b1;
      case (r_wr_state)
        WR_IDLE: begin
          if (w_aw_hs) begin
            r_aw_got <= 1'b1;
            r_awaddr <= s_axil.awaddr;
          end
          if (w_w_hs) begin
            r_w_got <= 1'b1;
            r_wdata <= s_axil.wdata;
            r_wstrb <= s_axil.wstrb;
          end
          if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
            r_wr_state <= WR_WRITE;
          end
        end
        WR_WRITE: begin
          r_aw_got   <= 1'b0;
          r_w_got    <= 1'b0;
          r_bvalid   <= 1'b1;
          r_bresp    <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
          r_wr_state <= WR_RESP;
        end
        WR_RESP: begin
          if (s_axil.bready) begin
            r_bvalid   <= 1'b0;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Register file updates, command pulse, sticky IRQ status (set beats clear) and registered IRQ line.
  always_ff @(posedge axilite_clk or posedge axilite_rst) begin
    if (axilite_rst) begin
      r_scratch   <= 32'h0;
      r_ctrl      <= 32'h0;
      r_irq_stat  <= 8'h00;
      r_irq_en    <= 8'h00;
      r_cmd_pulse <= 32'h0;
      r_irq       <= 1'b0;
    end else begin
      r_cmd_pulse <= 32'h0;
      if (w_wr_en && !w_wr_err) begin
        case (w_wr_idx)
          IDX_SCRATCH: r_scratch   <= (r_scratch & ~w_wmask) | (r_wdata & w_wmask);
          IDX_CTRL:    r_ctrl      <= (r_ctrl & ~w_wmask) | (r_wdata & w_wmask);
          IDX_IRQEN:   r_irq_en    <= (r_irq_en & ~w_wmask[7:0]) | (r_wdata[7:0] & w_wmask[7:0]);
          IDX_PULSE:   r_cmd_pulse <= r_wdata & w_wmask;
          default:     ;
        endcase
      end
      r_irq_stat <= (r_irq_stat & ~w_irq_clr) | irq_src_i;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  // Read channel FSM: register data on AR handshake, hold it until accepted.
  always_ff @(posedge axilite_clk or posedge axilite_rst) begin
    if (axilite_rst) begin
      r_rd_state <= RD_IDLE;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= 32'h0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rdata    <= w_rd_val;
            r_rresp    <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            r_rvalid   <= 1'b1;
            r_rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (s_axil.rready) begin
            r_rvalid   <= 1'b0;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// tb/tb_axil_reg_bank.sv - directed self-checking bench for axil_reg_bank
module tb_axil_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] status_i;
  logic [7:0]  irq_src_i;
  logic [31:0] ctrl_o;
  logic [31:0] cmd_pulse_o;
  logic        irq_o;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  logic [31:0] pulse_val = 32'h0;

  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [1:0]  wr_resp;
  int          pc0;

  axil_reg_bank_if #(.ADDR_W(12)) s_axil();

  axil_reg_bank #(.ADDR_W(12), .VERSION(32'h0001_0000)) dut (
    .axilite_clk (clk),
    .axilite_rst (rst),
    .s_axil      (s_axil),
    .status_i    (status_i),
    .irq_src_i   (irq_src_i),
    .ctrl_o      (ctrl_o),
    .cmd_pulse_o (cmd_pulse_o),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  // Count cycles in which the command pulse is non-zero.
  always @(negedge clk) begin
    if (cmd_pulse_o != 32'h0) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_val = cmd_pulse_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic axil_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int w_lead, input int b_hold, input logic [7:0] irq_at_write,
                         output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0;
    w_done  = 0;
    resp    = 2'bxx;
    @(negedge clk);
    s_axil.awaddr = a;
    s_axil.wdata  = d;
    s_axil.wstrb  = s;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      s_axil.wvalid  = !w_done;
      s_axil.awvalid = !aw_done && (c >= w_lead);
      #1;
      aw_hs = s_axil.awvalid && s_axil.awready;
      w_hs  = s_axil.wvalid && s_axil.wready;
      @(negedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
    end
    s_axil.awvalid = 1'b0;
    s_axil.wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      chk("wr_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    // This cycle is the register update cycle.
    chk("wr_rdy_low_in_write", {30'd0, s_axil.awready, s_axil.wready}, 32'd0);
    irq_src_i = irq_at_write;
    @(negedge clk);
    irq_src_i = 8'h00;
    chk("wr_bvalid_latency", {31'd0, s_axil.bvalid}, 32'd1);
    n = 0;
    while (!s_axil.bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_axil.bvalid) return;
    for (int h = 0; h < b_hold; h++) begin
      @(negedge clk);
      chk("wr_bvalid_held", {31'd0, s_axil.bvalid}, 32'd1);
      chk("wr_rdy_low_in_resp", {30'd0, s_axil.awready, s_axil.wready}, 32'd0);
    end
    resp = s_axil.bresp;
    s_axil.bready = 1'b1;
    @(negedge clk);
    s_axil.bready = 1'b0;
  endtask

  task automatic axil_rd(input logic [11:0] a, output logic [31:0] data, output logic [1:0] resp);
    bit done, hs;
    done = 0;
    data = 'x;
    resp = 'x;
    @(negedge clk);
    s_axil.araddr = a;
    for (int c = 0; c < 20 && !done; c++) begin
      s_axil.arvalid = 1'b1;
      #1;
      hs = s_axil.arvalid && s_axil.arready;
      @(negedge clk);
      if (hs) done = 1;
    end
    s_axil.arvalid = 1'b0;
    if (!done) begin
      chk("rd_handshake_timeout", 32'd0, 32'd1);
      return;
    end
    chk("rd_rvalid_latency", {31'd0, s_axil.rvalid}, 32'd1);
    if (!s_axil.rvalid) return;
    data = s_axil.rdata;
    resp = s_axil.rresp;
    s_axil.rready = 1'b1;
    @(negedge clk);
    s_axil.rready = 1'b0;
  endtask

  initial begin
    s_axil.awaddr  = '0;
    s_axil.awprot  = 3'b000;
    s_axil.awvalid = 1'b0;
    s_axil.wdata   = 32'h0;
    s_axil.wstrb   = 4'h0;
    s_axil.wvalid  = 1'b0;
    s_axil.bready  = 1'b0;
    s_axil.araddr  = '0;
    s_axil.arprot  = 3'b000;
    s_axil.arvalid = 1'b0;
    s_axil.rready  = 1'b0;
    status_i  = 32'hDEAD_BEEF;
    irq_src_i = 8'h00;

    // Reset and the one-cycle ready hold-off after release.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_awready_hold", {31'd0, s_axil.awready}, 32'd0);
    chk("rst_arready_hold", {31'd0, s_axil.arready}, 32'd0);
    chk("rst_outputs", {ctrl_o[15:0], 14'd0, s_axil.bvalid, s_axil.rvalid}, 32'd0);
    chk("rst_pulse_irq", {cmd_pulse_o[30:0], irq_o}, 32'd0);
    chk("rst_rdata", s_axil.rdata, 32'h0);
    @(negedge clk);
    chk("rst_readies_up", {29'd0, s_axil.awready, s_axil.wready, s_axil.arready}, 32'd7);

    axil_rd(12'h000, rd_data, rd_resp);
    chk("rd_version", rd_data, 32'h0001_0000);
    chk("rd_version_resp", {30'd0, rd_resp}, 32'd0);
    axil_rd(12'h008, rd_data, rd_resp);
    chk("rd_ctrl_reset", rd_data, 32'h0);

    // SCRATCH full write then byte-0 only.
    axil_wr(12'h004, 32'hA5A5_5A5A, 4'hF, 0, 0, 8'h00, wr_resp);
    chk("wr_scratch_resp", {30'd0, wr_resp}, 32'd0);
    axil_wr(12'h004, 32'h0000_00FF, 4'h1, 0, 0, 8'h00, wr_resp);
    chk("wr_scratch_b0_resp", {30'd0, wr_resp}, 32'd0);
    axil_rd(12'h004, rd_data, rd_resp);
    chk("rd_scratch_strb", rd_data, 32'hA5A5_5AFF);

    // W three cycles ahead of AW, response held off five cycles.
    axil_wr(12'h008, 32'h1234_5678, 4'hF, 3, 5, 8'h00, wr_resp);
    chk("wr_ctrl_resp", {30'd0, wr_resp}, 32'd0);
    chk("ctrl_o_value", ctrl_o, 32'h1234_5678);
    axil_rd(12'h008, rd_data, rd_resp);
    chk("rd_ctrl", rd_data, 32'h1234_5678);

    // Command pulse lasts exactly one cycle; PULSE reads zero.
    pc0 = pulse_cnt;
    axil_wr(12'h018, 32'h0000_0003, 4'hF, 0, 0, 8'h00, wr_resp);
    @(negedge clk);
    chk("pulse_cycles", pulse_cnt - pc0, 32'd1);
    chk("pulse_value", pulse_val, 32'h0000_0003);
    axil_rd(12'h018, rd_data, rd_resp);
    chk("rd_pulse_zero", rd_data, 32'h0);

    // Sticky interrupt, set-over-clear, W1C.
    axil_wr(12'h014, 32'h0000_0004, 4'hF, 0, 0, 8'h00, wr_resp);
    @(negedge clk);
    irq_src_i = 8'h04;
    @(negedge clk);
    irq_src_i = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("irq_o_set", {31'd0, irq_o}, 32'd1);
    axil_rd(12'h010, rd_data, rd_resp);
    chk("rd_irq_stat_set", rd_data, 32'h0000_0004);
    axil_wr(12'h010, 32'h0000_0004, 4'hF, 0, 0, 8'h04, wr_resp);
    axil_rd(12'h010, rd_data, rd_resp);
    chk("rd_irq_set_wins", rd_data, 32'h0000_0004);
    chk("irq_o_still_set", {31'd0, irq_o}, 32'd1);
    axil_wr(12'h010, 32'h0000_0004, 4'hF, 0, 0, 8'h00, wr_resp);
    axil_rd(12'h010, rd_data, rd_resp);
    chk("rd_irq_cleared", rd_data, 32'h0);
    chk("irq_o_cleared", {31'd0, irq_o}, 32'd0);
    axil_rd(12'h00C, rd_data, rd_resp);
    chk("rd_status", rd_data, 32'hDEAD_BEEF);

    // Error and read-only offsets.
    axil_rd(12'h040, rd_data, rd_resp);
    chk("rd_oob_data", rd_data, 32'h0);
    chk("rd_oob_resp", {30'd0, rd_resp}, 32'd2);
    axil_wr(12'h01C, 32'hFFFF_FFFF, 4'hF, 0, 0, 8'h00, wr_resp);
    chk("wr_rsvd_resp", {30'd0, wr_resp}, 32'd2);
    axil_wr(12'h024, 32'hFFFF_FFFF, 4'hF, 0, 0, 8'h00, wr_resp);
    chk("wr_oob_resp", {30'd0, wr_resp}, 32'd2);
    axil_wr(12'h000, 32'hFFFF_FFFF, 4'hF, 0, 0, 8'h00, wr_resp);
    chk("wr_ro_resp", {30'd0, wr_resp}, 32'd0);
    axil_rd(12'h000, rd_data, rd_resp);
    chk("rd_version_kept", rd_data, 32'h0001_0000);
    axil_rd(12'h004, rd_data, rd_resp);
    chk("rd_scratch_kept", rd_data, 32'hA5A5_5AFF);
    axil_rd(12'h01C, rd_data, rd_resp);
    chk("rd_rsvd_resp", {30'd0, rd_resp}, 32'd2);
    chk("ctrl_o_kept", ctrl_o, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axil_reg_bank.md
# axil_reg_bank

AXI4-Lite slave register bank that terminates the control-plane bus driven by the `WriteReg`/`ReadReg` bench tasks and by the PS AXI4-Lite master in hardware. It decodes a small fixed register map (version, scratch, control, status, sticky interrupt, command pulse) and converts bus writes into registered control outputs for the datapath. Write and read channels are handled by independent state machines with full valid/ready handshaking. It sits directly downstream of the AXI4-Lite master.

## Interface
- `ADDR_W`, 12, AXI4-Lite address width; only bits [4:2] are decoded, bits [1:0] ignored.
- `VERSION`, 32'h0001_0000, constant returned at offset 0x00.
- `axilite_clk`  in  1  bus and register clock.
- `axilite_rst`  in  1  asynchronous, active-high reset.
- `s_axil_awaddr`/`awprot`/`awvalid`/`awready`  in/in/in/out  ADDR_W/3/1/1  write address channel; `awprot` ignored.
- `s_axil_wdata`/`wstrb`/`wvalid`/`wready`  in/in/in/out  32/4/1/1  write data channel.
- `s_axil_bresp`/`bvalid`/`bready`  out/out/in  2/1/1  write response.
- `s_axil_araddr`/`arprot`/`arvalid`/`arready`  in/in/in/out  ADDR_W/3/1/1  read address; `arprot` ignored.
- `s_axil_rdata`/`rresp`/`rvalid`/`rready`  out/out/out/in  32/2/1/1  read data.
- `status_i`  in  32  live status, sampled on read.
- `irq_src_i`  in  8  interrupt event pulses, level-high per cycle.
- `ctrl_o`  out  32  CTRL register contents.
- `cmd_pulse_o`  out  32  one-cycle pulse of written PULSE data.
- `irq_o`  out  1  |(IRQ_STAT & IRQ_EN), registered.

## Operation
- Register map (byte offsets): 0x00 VERSION RO; 0x04 SCRATCH RW; 0x08 CTRL RW; 0x0C STATUS RO (`status_i`); 0x10 IRQ_STAT [7:0] sticky, W1C; 0x14 IRQ_EN [7:0] RW; 0x18 PULSE WO (reads 0); 0x1C reserved.
- Offsets ≥ 0x20, and 0x1C: write ignored, bresp = SLVERR (2'b10); read returns 32'h0, rresp = SLVERR. Mapped: OKAY (2'b00). Writes to RO offsets are ignored with OKAY.
- `wstrb` is a byte enable for RW, W1C and PULSE; disabled bytes unchanged / not cleared / pulse byte 0.
- Unused IRQ bits [31:8] read 0.
- Write FSM: IDLE -> (AW and W both captured) WRITE -> RESP -> IDLE. In IDLE, `awready` = 1 until an AW is captured, `wready` = 1 until a W is captured; AW and W are captured independently in either order or the same cycle. WRITE lasts one cycle and updates registers. RESP holds `bvalid` = 1 until `bready`; both readies are 0 during WRITE and RESP.
- Read FSM: IDLE (`arready` = 1) -> on AR handshake register rdata/rresp -> DATA (`rvalid` = 1, `arready` = 0) until `rready`, then IDLE.
- IRQ_STAT bit set by `irq_src_i` bit; a set and a W1C clear in the same cycle: set wins.
- Read and write FSMs are independent; a read handshake in the same cycle as a WRITE update returns the pre-write value.

## Timing
- Reset (async assert, sync deassert expected upstream): all registers 0, `awready` = `wready` = `arready` = 0 for the first cycle after release, then 1; `bvalid` = `rvalid` = 0; `bresp` = `rresp` = 0; `rdata` = 0; `ctrl_o` = 0; `cmd_pulse_o` = 0; `irq_o` = 0.
- Write latency: last of AW/W handshake at cycle N -> registers/`ctrl_o` updated at N+1 -> `bvalid` at N+1 (same edge as WRITE update completes, visible N+2 at latest; implement as `bvalid` asserted in the cycle after WRITE). `cmd_pulse_o` high exactly one cycle, the cycle after WRITE.
- Read latency: AR handshake at N -> `rvalid` at N+1; `rdata` stable while `rvalid` and not `rready`.
- `irq_o` follows IRQ_STAT/IRQ_EN with one-cycle register delay.
- Reset mid-transaction: all handshake state dropped, no response issued.

## Test plan
- Reset, read 0x00 -> rdata 32'h0001_0000, rresp OKAY; read 0x08 -> 0.
- Write 0x04 = 32'hA5A5_5A5A, wstrb 4'hF, then wstrb 4'h1 data 32'h0000_00FF -> read 0x04 = 32'hA5A5_5AFF, bresp OKAY both.
- W before AW (W valid 3 cycles early), bready held low 5 cycles -> `bvalid` held, readies low, CTRL written once.
- Write 0x18 = 32'h0000_0003 -> `cmd_pulse_o` = 3 for exactly one cycle; read 0x18 -> 0.
- IRQ_EN = 8'h04, pulse `irq_src_i` bit 2 -> IRQ_STAT = 8'h04, `irq_o` = 1; W1C 0x10 = 4 coincident with new bit-2 pulse -> stays 4; W1C alone -> 0, `irq_o` = 0.
- Read 0x40 / write 0x1C -> rresp/bresp = 2'b10, rdata 0, no register change.
